// File: rtl/exe_stage_mc_if.sv
// exe_stage_mc_if: ID/EXE bundle in, EXE/MEM bundle out, plus the upstream stall.
interface exe_stage_mc_if #(parameter int XLEN = 32);
    logic            flush;
    logic            valid_in;
    logic [XLEN-1:0] Val1_in;
    logic [XLEN-1:0] Val2_in;
    logic [XLEN-1:0] Reg2_in;
    logic [4:0]      Dest_in;
    logic [3:0]      EXE_CMD_in;
    logic            MEM_R_EN_in;
    logic            MEM_W_EN_in;
    logic            WB_EN_in;
    logic            stall;
    logic            valid_out;
    logic [XLEN-1:0] ALU_result;
    logic [XLEN-1:0] Reg2;
    logic [4:0]      Dest;
    logic            MEM_R_EN;
    logic            MEM_W_EN;
    logic            WB_EN;
    modport master (
        output flush, valid_in, Val1_in, Val2_in, Reg2_in, Dest_in, EXE_CMD_in,
               MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
        input  stall, valid_out, ALU_result, Reg2, Dest, MEM_R_EN, MEM_W_EN, WB_EN
    );
    modport slave (
        input  flush, valid_in, Val1_in, Val2_in, Reg2_in, Dest_in, EXE_CMD_in,
               MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
        output stall, valid_out, ALU_result, Reg2, Dest, MEM_R_EN, MEM_W_EN, WB_EN
    );
endinterface

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with single-cycle ALU ops and iterative MUL/DIVU/REMU.
module exe_stage_mc #(parameter int XLEN = 32) (
    input logic          clk,
    input logic          rst,
    exe_stage_mc_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
    localparam logic [3:0] MUL = 4'b1100, DIVU = 4'b1101, REMU = 4'b1110;
    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a, b, c;
    logic [3:0]      op;
    logic [XLEN-1:0] reg2_q;
    logic [4:0]      dest_q;
    logic            mr_q, mw_q, wb_q;
    logic            multi, ge;
    logic [XLEN-1:0] alu, a_n, b_n, c_n, mc_res;
    logic [XLEN:0]   r_sh;
    logic [4:0]      sh;
    assign multi = bus.EXE_CMD_in inside {MUL, DIVU, REMU};
    assign sh    = bus.Val2_in[4:0];
    assign bus.stall = !rst && !bus.flush &&
                       (state == IDLE ? bus.valid_in && multi : cnt != '0);
    always_comb begin
        case (bus.EXE_CMD_in)
            4'b0010: alu = bus.Val1_in - bus.Val2_in;
            4'b0100: alu = bus.Val1_in & bus.Val2_in;
            4'b0101: alu = bus.Val1_in | bus.Val2_in;
            4'b0110: alu = ~(bus.Val1_in | bus.Val2_in);
            4'b0111: alu = bus.Val1_in ^ bus.Val2_in;
            4'b1000: alu = bus.Val1_in << sh;
            4'b1001: alu = $signed(bus.Val1_in) >>> sh;
            4'b1010: alu = bus.Val1_in >> sh;
            default: alu = bus.Val1_in + bus.Val2_in;
        endcase
    end
    // a/b/c: accumulator/multiplicand/multiplier for MUL, remainder/divisor/quotient for divides
    always_comb begin
        r_sh   = {a, c[XLEN-1]};
        ge     = r_sh >= {1'b0, b};
        a_n    = op == MUL ? a + (c[0] ? b : '0) :
                 ge ? XLEN'(r_sh - {1'b0, b}) : r_sh[XLEN-1:0];
        b_n    = op == MUL ? b << 1 : b;
        c_n    = op == MUL ? c >> 1 : {c[XLEN-2:0], ge};
        mc_res = op == DIVU ? c_n : a_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            a              <= '0;
            b              <= '0;
            c              <= '0;
            op             <= '0;
            reg2_q         <= '0;
            dest_q         <= '0;
            mr_q           <= 1'b0;
            mw_q           <= 1'b0;
            wb_q           <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.ALU_result <= '0;
            bus.Reg2       <= '0;
            bus.Dest       <= '0;
            bus.MEM_R_EN   <= 1'b0;
            bus.MEM_W_EN   <= 1'b0;
            bus.WB_EN      <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.MEM_R_EN  <= 1'b0;
            bus.MEM_W_EN  <= 1'b0;
            bus.WB_EN     <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == IDLE) begin
                if (bus.valid_in && multi) begin
                    state  <= BUSY;
                    cnt    <= CW'(XLEN - 1);
                    op     <= bus.EXE_CMD_in;
                    a      <= '0;
                    b      <= bus.EXE_CMD_in == MUL ? bus.Val1_in : bus.Val2_in;
                    c      <= bus.EXE_CMD_in == MUL ? bus.Val2_in : bus.Val1_in;
                    reg2_q <= bus.Reg2_in;
                    dest_q <= bus.Dest_in;
                    mr_q   <= bus.MEM_R_EN_in;
                    mw_q   <= bus.MEM_W_EN_in;
                    wb_q   <= bus.WB_EN_in;
                end else if (bus.valid_in) begin
                    bus.valid_out  <= 1'b1;
                    bus.ALU_result <= alu;
                    bus.Reg2       <= bus.Reg2_in;
                    bus.Dest       <= bus.Dest_in;
                    bus.MEM_R_EN   <= bus.MEM_R_EN_in;
                    bus.MEM_W_EN   <= bus.MEM_W_EN_in;
                    bus.WB_EN      <= bus.WB_EN_in;
                end
            end else begin
                a   <= a_n;
                b   <= b_n;
                c   <= c_n;
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    state          <= IDLE;
                    bus.valid_out  <= 1'b1;
                    bus.ALU_result <= mc_res;
                    bus.Reg2       <= reg2_q;
                    bus.Dest       <= dest_q;
                    bus.MEM_R_EN   <= mr_q;
                    bus.MEM_W_EN   <= mw_q;
                    bus.WB_EN      <= wb_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed and random instruction streams checked cycle by cycle
// against an arithmetic reference of the execute stage's latency and results.
module tb_exe_stage_mc;
    localparam int XLEN = 32;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0010, NOR = 4'b0110, SRA = 4'b1001,
                           MUL = 4'b1100, DIVU = 4'b1101, REMU = 4'b1110;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    exe_stage_mc_if #(.XLEN(XLEN)) bus();
    exe_stage_mc #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    int left = 0;
    logic [31:0] p_res, p_reg2, e_res, e_reg2;
    logic [4:0]  p_dest, e_dest;
    logic        p_mr, p_mw, p_wb, e_valid, e_mr, e_mw, e_wb;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0010: return x - y;
            4'b0100: return x & y;
            4'b0101: return x | y;
            4'b0110: return ~(x | y);
            4'b0111: return x ^ y;
            4'b1000: return x << y[4:0];
            4'b1001: return $signed(x) >>> y[4:0];
            4'b1010: return x >> y[4:0];
            4'b1100: return x * y;
            4'b1101: return y == 0 ? 32'hFFFF_FFFF : x / y;
            4'b1110: return y == 0 ? x : x % y;
            default: return x + y;
        endcase
    endfunction
    function automatic logic is_multi(input logic [3:0] c);
        return c == MUL || c == DIVU || c == REMU;
    endfunction
    // One clock: check stall on current inputs, advance the model, check registered outputs.
    task automatic tick();
        logic exp_stall;
        #1;
        exp_stall = !rst && !bus.flush &&
                    (left == 0 ? bus.valid_in && is_multi(bus.EXE_CMD_in) : left > 1);
        check("stall", bus.stall, exp_stall);
        {e_valid, e_mr, e_mw, e_wb} = '0;
        if (rst) begin
            left = 0;
            {e_res, e_reg2, e_dest} = '0;
        end else if (bus.flush) begin
            left = 0;
        end else if (left > 0) begin
            if (left == 1)
                {e_valid, e_res, e_reg2, e_dest, e_mr, e_mw, e_wb} = {1'b1, p_res, p_reg2, p_dest, p_mr, p_mw, p_wb};
            left--;
        end else if (bus.valid_in) begin
            if (is_multi(bus.EXE_CMD_in)) begin
                left = XLEN;
                p_res = ref_alu(bus.EXE_CMD_in, bus.Val1_in, bus.Val2_in);
                {p_reg2, p_dest, p_mr, p_mw, p_wb} = {bus.Reg2_in, bus.Dest_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in};
            end else begin
                e_valid = 1'b1;
                e_res = ref_alu(bus.EXE_CMD_in, bus.Val1_in, bus.Val2_in);
                {e_reg2, e_dest, e_mr, e_mw, e_wb} = {bus.Reg2_in, bus.Dest_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in};
            end
        end
        @(posedge clk);
        #1;
        check("valid_out", bus.valid_out, e_valid);
        check("ALU_result", bus.ALU_result, e_res);
        check("Reg2", bus.Reg2, e_reg2);
        check("Dest", bus.Dest, e_dest);
        check("ctrl", {bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN}, {e_mr, e_mw, e_wb});
    endtask
    task automatic drive(input logic v, input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] r2, input logic [4:0] d, input logic mr, input logic mw, input logic wb);
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.valid_in = v;
        bus.EXE_CMD_in = cmd;
        bus.Val1_in = v1;
        bus.Val2_in = v2;
        bus.Reg2_in = r2;
        bus.Dest_in = d;
        bus.MEM_R_EN_in = mr;
        bus.MEM_W_EN_in = mw;
        bus.WB_EN_in = wb;
    endtask
    task automatic junk();
        drive(1'b1, 4'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask
    task automatic op(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] d);
        drive(1'b1, cmd, v1, v2, $urandom, d, 1'b0, 1'b0, 1'b1);
        tick();
    endtask
    task automatic mc(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] exp);
        op(cmd, v1, v2, 5'd3);
        repeat (XLEN) begin
            junk();
            tick();
        end
        check("mc_result", bus.ALU_result, exp);
    endtask
    initial begin
        junk();
        rst = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) tick();
        check("rst_zero", {bus.valid_out, bus.ALU_result, bus.Dest, bus.WB_EN}, '0);
        op(ADD, 5, 7, 5'd1);
        check("add", {bus.valid_out, bus.ALU_result}, {1'b1, 32'd12});
        op(SUB, 3, 5, 5'd2);
        check("sub", bus.ALU_result, 32'hFFFF_FFFE);
        op(SRA, 32'h8000_0000, 4, 5'd4);
        check("sra", bus.ALU_result, 32'hF800_0000);
        op(NOR, 0, 0, 5'd6);
        check("nor", {bus.valid_out, bus.ALU_result, bus.Dest, bus.WB_EN}, {1'b1, 32'hFFFF_FFFF, 5'd6, 1'b1});
        // store-with-MUL: write enable and store data only in the result cycle
        drive(1'b1, MUL, 7, 6, 32'hDEAD_BEEF, 5'd9, 1'b0, 1'b1, 1'b0);
        tick();
        repeat (XLEN) begin
            junk();
            tick();
        end
        check("mul", {bus.valid_out, bus.ALU_result, bus.Dest, bus.Reg2, bus.MEM_W_EN},
              {1'b1, 32'd42, 5'd9, 32'hDEAD_BEEF, 1'b1});
        op(ADD, 1, 1, 5'd5);
        check("add_after_mul", {bus.valid_out, bus.ALU_result}, {1'b1, 32'd2});
        mc(DIVU, 100, 7, 14);
        mc(REMU, 100, 7, 2);
        mc(DIVU, 32'h1357_9BDF, 0, 32'hFFFF_FFFF);
        mc(REMU, 32'h1234, 0, 32'h1234);
        op(MUL, 7, 6, 5'd9);
        repeat (9) begin
            junk();
            tick();
        end
        junk();
        bus.flush = 1'b1;
        tick();
        repeat (30) begin
            drive(1'b0, ADD, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        op(ADD, 20, 22, 5'd7);
        check("add_after_flush", {bus.valid_out, bus.ALU_result}, {1'b1, 32'd42});
        op(MUL, 7, 6, 5'd9);
        repeat (9) begin
            junk();
            tick();
        end
        junk();
        rst = 1'b1;
        tick();
        check("rst_busy", {bus.valid_out, bus.ALU_result, bus.Reg2, bus.Dest, bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN}, '0);
        repeat (30) begin
            drive(1'b0, ADD, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        op(ADD, 2, 3, 5'd8);
        check("add_after_rst", {bus.valid_out, bus.ALU_result}, {1'b1, 32'd5});
        repeat (1500) begin
            logic [31:0] v1, v2;
            v1 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 300)) : $urandom;
            v2 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), v1, v2, $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            bus.flush = $urandom_range(0, 39) == 0;
            rst = $urandom_range(0, 149) == 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Multicycle execute stage for the MIPS pipeline. It consumes the instruction bundle held in the ID/EXE pipeline register (operands, destination, EXE command, memory and writeback enables) and executes it. Single-cycle ALU ops complete in one cycle. Multiply, divide and remainder run iteratively, and `stall` freezes the ID/EXE register and earlier stages until the result is ready. Results are registered and presented as a bundle with `valid_out` for the EXE/MEM register.

## Interface
Parameters:
- `XLEN`, 32: datapath width; iteration count equals `XLEN`.

Ports (clock, reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard in-flight and current instruction.
- `valid_in` in 1: ID/EXE register holds a live instruction.
- `Val1_in` in XLEN: operand A.
- `Val2_in` in XLEN: operand B, or immediate.
- `Reg2_in` in XLEN: store data, passed through.
- `Dest_in` in 5: destination register.
- `EXE_CMD_in` in 4: operation select.
- `MEM_R_EN_in`, `MEM_W_EN_in`, `WB_EN_in` in 1 each: control passed through.
- `stall` out 1: freeze upstream stages (combinational).
- `valid_out` out 1: result bundle valid this cycle.
- `ALU_result` out XLEN: result.
- `Reg2` out XLEN, `Dest` out 5: forwarded fields.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN` out 1 each: forwarded controls.

## Operation
EXE_CMD encoding (any other code executes as ADD):
- 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
- 1000 SLL, 1001 SRA, 1010 SRL; shift amount is `Val2_in[4:0]`, `Val1_in` is shifted.
- 1100 MUL: low XLEN bits of the product, using unsigned shift-add.
- 1101 DIVU: unsigned quotient. 1110 REMU: unsigned remainder. Both use a restoring divider.
- Divide by zero: DIVU gives all ones; REMU gives the dividend. Iterations still run the full count.
- All arithmetic is modulo 2^XLEN; no overflow flags.

States:
- IDLE: if `valid_in` and the op is single-cycle, compute and register the result bundle; `valid_out`=1 next cycle. If `valid_in` and the op is MUL/DIVU/REMU, latch operands, Reg2, Dest and controls; set counter to XLEN-1; go to BUSY.
- BUSY: one multiply or divide iteration per cycle. Inputs are ignored, including `valid_in`. When the counter reaches 0, register the final result with `valid_out`=1 next cycle and return to IDLE.

Stall and bubbles:
- `stall` = (IDLE & `valid_in` & multicycle op & !`flush`) | (BUSY & counter≠0).
- When `valid_out`=0, `WB_EN`, `MEM_R_EN` and `MEM_W_EN` are driven 0 (bubble). `ALU_result`, `Reg2` and `Dest` hold their last values.

Flush and reset:
- `flush` in any state: go to IDLE; `valid_out`=0 next cycle; the current instruction is dropped; `stall`=0 that cycle.
- `rst`: state IDLE, counter 0. Every output register is 0: `valid_out`, `ALU_result`, `Reg2`, `Dest`, `MEM_R_EN`, `MEM_W_EN`, `WB_EN`. `stall`=0 while `rst` is high.
- `rst` has priority over `flush`; `flush` has priority over `valid_in`.

## Timing
- Single-cycle op accepted at edge-cycle T: bundle visible at T+1. Back-to-back issue gives one result per cycle.
- Multicycle op accepted at T:
  - `stall`=1 for cycles T..T+XLEN-1 (32 cycles).
  - Final iteration at T+XLEN with `stall`=0, so upstream loads the next instruction on that edge.
  - Result with `valid_out`=1 at T+XLEN+1 (latency 33).
- The instruction loaded at end of T+XLEN is accepted in IDLE at T+XLEN+1; its single-cycle result appears at T+XLEN+2. No result collision.
- Reset mid-BUSY or flush mid-BUSY: the partial result is discarded; no `valid_out` pulse follows.

## Test plan
- Reset: hold `rst` 2 cycles with garbage inputs -> all outputs 0, `stall`=0. First ADD 5+7 issued after release -> `ALU_result`=12, `valid_out`=1 one cycle later.
- ALU sweep, back-to-back: SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000>>4 -> 0xF8000000; NOR 0,0 -> 0xFFFFFFFF. Expect `valid_out` on consecutive cycles with `Dest` and `WB_EN` forwarded.
- MUL 7×6 with `Dest`=9 -> `stall` high exactly 32 cycles, `ALU_result`=42 at cycle T+33. Following ADD 1+1 -> 2 at T+34.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- `flush` at BUSY cycle 10 of a MUL -> `stall` drops that cycle, no `valid_out`, and the next ADD completes normally. Repeat with `rst` at cycle 10 -> all outputs 0.
- Store-with-MUL check: `MEM_W_EN_in`=1, `Reg2_in`=0xDEADBEEF on a MUL -> `MEM_W_EN`=1 and `Reg2`=0xDEADBEEF only in the `valid_out` cycle; `MEM_W_EN`=0 on every stall cycle.
